// File: rtl/decode_exec_pipe_if.sv
// ID/EX boundary bundle: decoder-side inputs, execute-side registered twins,
// plus stall/halt/bubble-count status.
interface decode_exec_pipe_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8
) ();
    localparam int VW = ELEM_SIZE * VECT_SIZE;

    logic                 valid_i;
    logic                 flush_i;
    logic                 hold_i;
    logic [REGI_SIZE-1:0] int_op1_i, int_op2_i;
    logic [VW-1:0]        v_op1_i, v_op2_i;
    logic [REGI_BITS-1:0] int_src1_i, int_src2_i;
    logic [1:0]           int_src_use_i;
    logic [VECT_BITS-1:0] v_src1_i, v_src2_i;
    logic [1:0]           v_src_use_i;
    logic [REGI_BITS-1:0] int_dest_i;
    logic [VECT_BITS-1:0] v_dest_i;
    logic [9:0]           ctrl_i;
    logic [7:0]           imm_i;
    logic [2:0]           alu_op_i;
    logic [1:0]           cond_i;
    logic [9:0]           jump_addr_i;
    logic [2:0]           swap_org_i, swap_dst_i;
    logic [REGI_SIZE-1:0] next_pc_i;

    logic [REGI_SIZE-1:0] int_op1_o, int_op2_o;
    logic [VW-1:0]        v_op1_o, v_op2_o;
    logic [REGI_BITS-1:0] int_src1_o, int_src2_o;
    logic [1:0]           int_src_use_o;
    logic [VECT_BITS-1:0] v_src1_o, v_src2_o;
    logic [1:0]           v_src_use_o;
    logic [REGI_BITS-1:0] int_dest_o;
    logic [VECT_BITS-1:0] v_dest_o;
    logic [9:0]           ctrl_o;
    logic [7:0]           imm_o;
    logic [2:0]           alu_op_o;
    logic [1:0]           cond_o;
    logic [9:0]           jump_addr_o;
    logic [2:0]           swap_org_o, swap_dst_o;
    logic [REGI_SIZE-1:0] next_pc_o;
    logic                 valid_o;
    logic                 stall_o;
    logic                 halted_o;
    logic [15:0]          bubble_cnt_o;

    modport slave (
        input  valid_i, flush_i, hold_i, int_op1_i, int_op2_i, v_op1_i, v_op2_i,
               int_src1_i, int_src2_i, int_src_use_i, v_src1_i, v_src2_i,
               v_src_use_i, int_dest_i, v_dest_i, ctrl_i, imm_i, alu_op_i,
               cond_i, jump_addr_i, swap_org_i, swap_dst_i, next_pc_i,
        output int_op1_o, int_op2_o, v_op1_o, v_op2_o, int_src1_o, int_src2_o,
               int_src_use_o, v_src1_o, v_src2_o, v_src_use_o, int_dest_o,
               v_dest_o, ctrl_o, imm_o, alu_op_o, cond_o, jump_addr_o,
               swap_org_o, swap_dst_o, next_pc_o, valid_o, stall_o, halted_o,
               bubble_cnt_o
    );

    modport master (
        output valid_i, flush_i, hold_i, int_op1_i, int_op2_i, v_op1_i, v_op2_i,
               int_src1_i, int_src2_i, int_src_use_i, v_src1_i, v_src2_i,
               v_src_use_i, int_dest_i, v_dest_i, ctrl_i, imm_i, alu_op_i,
               cond_i, jump_addr_i, swap_org_i, swap_dst_i, next_pc_i,
        input  int_op1_o, int_op2_o, v_op1_o, v_op2_o, int_src1_o, int_src2_o,
               int_src_use_o, v_src1_o, v_src2_o, v_src_use_o, int_dest_o,
               v_dest_o, ctrl_o, imm_o, alu_op_o, cond_o, jump_addr_o,
               swap_org_o, swap_dst_o, next_pc_o, valid_o, stall_o, halted_o,
               bubble_cnt_o
    );
endinterface

// File: rtl/decode_exec_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold,
// sticky end-of-program halt and a saturating bubble counter.
//   state | meaning
//   RUN   | normal capture / bubble / hold operation
//   HALT  | end instruction retired into EX; bubbles until reset
module decode_exec_pipe #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    decode_exec_pipe_if.slave     bus
);
    localparam int VW = ELEM_SIZE * VECT_SIZE;
    localparam int C_MEM_READ = 8;
    localparam int C_END      = 7;
    localparam int C_ALU_V    = 1;
    localparam logic [9:0] CTRL_NOP = 10'b00_0100_0000;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic                 valid;
        logic [9:0]           ctrl;
        logic [REGI_SIZE-1:0] int_op1, int_op2;
        logic [VW-1:0]        v_op1, v_op2;
        logic [REGI_BITS-1:0] int_src1, int_src2;
        logic [1:0]           int_src_use;
        logic [VECT_BITS-1:0] v_src1, v_src2;
        logic [1:0]           v_src_use;
        logic [REGI_BITS-1:0] int_dest;
        logic [VECT_BITS-1:0] v_dest;
        logic [7:0]           imm;
        logic [2:0]           alu_op;
        logic [1:0]           cond;
        logic [9:0]           jump_addr;
        logic [2:0]           swap_org, swap_dst;
        logic [REGI_SIZE-1:0] next_pc;
    } stage_t;

    state_t state_q, state_d;
    stage_t pipe_q, pipe_d, bubble, capture;
    logic [15:0] cnt_q, cnt_d;
    logic lu, int_hit, vec_hit;

    always_comb begin
        bubble      = '0;
        bubble.ctrl = CTRL_NOP;

        capture             = '0;
        capture.valid       = 1'b1;
        capture.ctrl        = bus.ctrl_i;
        capture.int_op1     = bus.int_op1_i;
        capture.int_op2     = bus.int_op2_i;
        capture.v_op1       = bus.v_op1_i;
        capture.v_op2       = bus.v_op2_i;
        capture.int_src1    = bus.int_src1_i;
        capture.int_src2    = bus.int_src2_i;
        capture.int_src_use = bus.int_src_use_i;
        capture.v_src1      = bus.v_src1_i;
        capture.v_src2      = bus.v_src2_i;
        capture.v_src_use   = bus.v_src_use_i;
        capture.int_dest    = bus.int_dest_i;
        capture.v_dest      = bus.v_dest_i;
        capture.imm         = bus.imm_i;
        capture.alu_op      = bus.alu_op_i;
        capture.cond        = bus.cond_i;
        capture.jump_addr   = bus.jump_addr_i;
        capture.swap_org    = bus.swap_org_i;
        capture.swap_dst    = bus.swap_dst_i;
        capture.next_pc     = bus.next_pc_i;
    end

    // Hazard is against the load currently sitting in EX; an EX bubble never matches.
    always_comb begin
        int_hit = (bus.int_src_use_i[0] && (bus.int_src1_i == pipe_q.int_dest)) ||
                  (bus.int_src_use_i[1] && (bus.int_src2_i == pipe_q.int_dest));
        vec_hit = (bus.v_src_use_i[0] && (bus.v_src1_i == pipe_q.v_dest)) ||
                  (bus.v_src_use_i[1] && (bus.v_src2_i == pipe_q.v_dest));
        lu = pipe_q.valid && pipe_q.ctrl[C_MEM_READ] && bus.valid_i &&
             (pipe_q.ctrl[C_ALU_V] ? vec_hit : int_hit);
    end

    always_comb begin
        state_d     = state_q;
        pipe_d      = pipe_q;
        cnt_d       = cnt_q;
        bus.stall_o = 1'b0;
        case (state_q)
            RUN: begin
                bus.stall_o = !bus.flush_i && (bus.hold_i || lu);
                if (bus.flush_i) begin
                    pipe_d = bubble;
                end else if (bus.hold_i) begin
                    pipe_d = pipe_q;
                end else if (lu) begin
                    pipe_d = bubble;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (bus.valid_i) begin
                    pipe_d = capture;
                    if (bus.ctrl_i[C_END]) begin
                        state_d = HALT;
                    end
                end else begin
                    pipe_d = bubble;
                end
            end
            HALT: begin
                bus.stall_o = 1'b1;
                pipe_d      = bubble;
            end
            default: begin
                state_d = RUN;
                pipe_d  = bubble;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            pipe_q  <= bubble;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_o       = pipe_q.valid;
    assign bus.ctrl_o        = pipe_q.ctrl;
    assign bus.int_op1_o     = pipe_q.int_op1;
    assign bus.int_op2_o     = pipe_q.int_op2;
    assign bus.v_op1_o       = pipe_q.v_op1;
    assign bus.v_op2_o       = pipe_q.v_op2;
    assign bus.int_src1_o    = pipe_q.int_src1;
    assign bus.int_src2_o    = pipe_q.int_src2;
    assign bus.int_src_use_o = pipe_q.int_src_use;
    assign bus.v_src1_o      = pipe_q.v_src1;
    assign bus.v_src2_o      = pipe_q.v_src2;
    assign bus.v_src_use_o   = pipe_q.v_src_use;
    assign bus.int_dest_o    = pipe_q.int_dest;
    assign bus.v_dest_o      = pipe_q.v_dest;
    assign bus.imm_o         = pipe_q.imm;
    assign bus.alu_op_o      = pipe_q.alu_op;
    assign bus.cond_o        = pipe_q.cond;
    assign bus.jump_addr_o   = pipe_q.jump_addr;
    assign bus.swap_org_o    = pipe_q.swap_org;
    assign bus.swap_dst_o    = pipe_q.swap_dst;
    assign bus.next_pc_o     = pipe_q.next_pc;
    assign bus.halted_o      = (state_q == HALT);
    assign bus.bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_decode_exec_pipe.sv
// Directed vector bench for decode_exec_pipe: table of per-cycle stimulus with
// expected stall (before the edge) and registered outputs (after the edge).
module tb_decode_exec_pipe;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int checks = 0;
    int errors = 0;

    decode_exec_pipe_if bus ();
    decode_exec_pipe dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    localparam logic [9:0] C_NOP  = 10'h040;
    localparam logic [9:0] C_LD   = 10'h104;
    localparam logic [9:0] C_VLD  = 10'h106;
    localparam logic [9:0] C_ALU  = 10'h001;
    localparam logic [9:0] C_VALU = 10'h002;
    localparam logic [9:0] C_END  = 10'h080;

    typedef struct {
        logic        v, fl, ho;
        logic [15:0] op1;
        logic [2:0]  alu;
        logic [3:0]  src1;
        logic [1:0]  use_;
        logic [3:0]  dest;
        logic [1:0]  vsrc2, vuse, vdest;
        logic [9:0]  ctrl;
        logic        e_stall, e_valid;
        logic [15:0] e_op1;
        logic [2:0]  e_alu;
        logic [9:0]  e_ctrl;
        logic [3:0]  e_dest;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.valid_i       = t.v;
        bus.flush_i       = t.fl;
        bus.hold_i        = t.ho;
        bus.int_op1_i     = t.op1;
        bus.alu_op_i      = t.alu;
        bus.int_src1_i    = t.src1;
        bus.int_src_use_i = t.use_;
        bus.int_dest_i    = t.dest;
        bus.v_src2_i      = t.vsrc2;
        bus.v_src_use_i   = t.vuse;
        bus.v_dest_i      = t.vdest;
        bus.ctrl_i        = t.ctrl;
    endtask

    task automatic check_outs(input string tag, input vec_t t);
        chk({tag, " valid_o"}, 32'(bus.valid_o), 32'(t.e_valid));
        chk({tag, " int_op1_o"}, 32'(bus.int_op1_o), 32'(t.e_op1));
        chk({tag, " alu_op_o"}, 32'(bus.alu_op_o), 32'(t.e_alu));
        chk({tag, " ctrl_o"}, 32'(bus.ctrl_o), 32'(t.e_ctrl));
        chk({tag, " int_dest_o"}, 32'(bus.int_dest_o), 32'(t.e_dest));
        chk({tag, " halted_o"}, 32'(bus.halted_o), 32'(t.e_halt));
        chk({tag, " bubble_cnt_o"}, 32'(bus.bubble_cnt_o), 32'(t.e_cnt));
    endtask

    // fields: v fl ho op1 alu src1 use dest vsrc2 vuse vdest ctrl | stall valid op1 alu ctrl dest halt cnt
    task automatic add(input logic v, fl, ho, input logic [15:0] op1, input logic [2:0] alu,
                       input logic [3:0] src1, input logic [1:0] use_, input logic [3:0] dest,
                       input logic [1:0] vsrc2, vuse, vdest, input logic [9:0] ctrl,
                       input logic e_stall, e_valid, input logic [15:0] e_op1,
                       input logic [2:0] e_alu, input logic [9:0] e_ctrl,
                       input logic [3:0] e_dest, input logic e_halt, input logic [15:0] e_cnt);
        vec_t t;
        t = '{v, fl, ho, op1, alu, src1, use_, dest, vsrc2, vuse, vdest, ctrl,
              e_stall, e_valid, e_op1, e_alu, e_ctrl, e_dest, e_halt, e_cnt};
        vq.push_back(t);
    endtask

    initial begin
        vec_t t;
        bus.valid_i = 0; bus.flush_i = 0; bus.hold_i = 0;
        bus.int_op1_i = 0; bus.int_op2_i = 0; bus.v_op1_i = 0; bus.v_op2_i = 0;
        bus.int_src1_i = 0; bus.int_src2_i = 0; bus.int_src_use_i = 0;
        bus.v_src1_i = 0; bus.v_src2_i = 0; bus.v_src_use_i = 0;
        bus.int_dest_i = 0; bus.v_dest_i = 0; bus.ctrl_i = 0; bus.imm_i = 0;
        bus.alu_op_i = 0; bus.cond_i = 0; bus.jump_addr_i = 0;
        bus.swap_org_i = 0; bus.swap_dst_i = 0; bus.next_pc_i = 0;

        // pass-through, load-use, non-matching src
        add(1,0,0,16'h1234,5,0,2'b00,1,0,0,0,C_ALU,  0,1,16'h1234,5,C_ALU,1,0,0);
        add(1,0,0,16'h0011,0,0,2'b00,3,0,0,0,C_LD,   0,1,16'h0011,0,C_LD ,3,0,0);
        add(1,0,0,16'h0022,2,3,2'b01,5,0,0,0,C_ALU,  1,0,16'h0000,0,C_NOP,0,0,1);
        add(1,0,0,16'h0022,2,3,2'b01,5,0,0,0,C_ALU,  0,1,16'h0022,2,C_ALU,5,0,1);
        add(1,0,0,16'h0033,0,0,2'b00,3,0,0,0,C_LD,   0,1,16'h0033,0,C_LD ,3,0,1);
        add(1,0,0,16'h0044,1,4,2'b01,6,0,0,0,C_ALU,  0,1,16'h0044,1,C_ALU,6,0,1);
        // flush with concurrent hazard
        add(1,0,0,16'h0055,0,0,2'b00,7,0,0,0,C_LD,   0,1,16'h0055,0,C_LD ,7,0,1);
        add(1,1,0,16'h0066,0,7,2'b01,0,0,0,0,C_ALU,  0,0,16'h0000,0,C_NOP,0,0,1);
        // hold over a hazard for three cycles, then hazard re-detected
        add(1,0,0,16'h0077,0,0,2'b00,2,0,0,0,C_LD,   0,1,16'h0077,0,C_LD ,2,0,1);
        add(1,0,1,16'h0088,3,2,2'b01,4,0,0,0,C_ALU,  1,1,16'h0077,0,C_LD ,2,0,1);
        add(1,0,1,16'h0099,3,2,2'b01,4,0,0,0,C_ALU,  1,1,16'h0077,0,C_LD ,2,0,1);
        add(1,0,1,16'h00AA,3,2,2'b01,4,0,0,0,C_ALU,  1,1,16'h0077,0,C_LD ,2,0,1);
        add(1,0,0,16'h00AA,3,2,2'b01,4,0,0,0,C_ALU,  1,0,16'h0000,0,C_NOP,0,0,2);
        add(1,0,0,16'h00AA,3,2,2'b01,4,0,0,0,C_ALU,  0,1,16'h00AA,3,C_ALU,4,0,2);
        // matching index but use bit clear
        add(1,0,0,16'h00BB,0,0,2'b00,9,0,0,0,C_LD,   0,1,16'h00BB,0,C_LD ,9,0,2);
        add(1,0,0,16'h00CC,4,9,2'b00,1,0,0,0,C_ALU,  0,1,16'h00CC,4,C_ALU,1,0,2);
        // vector load-use on source 2
        add(1,0,0,16'h00DD,0,0,2'b00,0,0,0,2,C_VLD,  0,1,16'h00DD,0,C_VLD,0,0,2);
        add(1,0,0,16'h00EE,0,0,2'b00,0,2,2'b10,0,C_VALU,1,0,16'h0000,0,C_NOP,0,0,3);
        add(1,0,0,16'h00EE,0,0,2'b00,0,2,2'b10,0,C_VALU,0,1,16'h00EE,0,C_VALU,0,0,3);
        // vector load does not trigger on an integer index match
        add(1,0,0,16'h0F00,0,0,2'b00,5,0,0,1,C_VLD,  0,1,16'h0F00,0,C_VLD,5,0,3);
        add(1,0,0,16'h0F0F,6,5,2'b01,2,0,0,0,C_ALU,  0,1,16'h0F0F,6,C_ALU,2,0,3);
        // invalid decoder slot is captured as a bubble
        add(0,0,0,16'hABCD,7,0,2'b00,8,0,0,0,C_ALU,  0,0,16'h0000,0,C_NOP,0,0,3);
        // end instruction retires into EX, then HALT ignores flush/hold
        add(1,0,0,16'h0E0E,1,0,2'b00,3,0,0,0,C_END,  0,1,16'h0E0E,1,C_END,3,1,3);
        add(1,0,0,16'h1111,2,0,2'b00,4,0,0,0,C_ALU,  1,0,16'h0000,0,C_NOP,0,1,3);
        add(1,0,1,16'h2222,2,0,2'b00,4,0,0,0,C_ALU,  1,0,16'h0000,0,C_NOP,0,1,3);
        add(1,1,0,16'h3333,2,0,2'b00,4,0,0,0,C_ALU,  1,0,16'h0000,0,C_NOP,0,1,3);

        rst_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst valid_o", 32'(bus.valid_o), 0);
        chk("rst ctrl_o", 32'(bus.ctrl_o), 32'(C_NOP));
        chk("rst halted_o", 32'(bus.halted_o), 0);
        chk("rst bubble_cnt_o", 32'(bus.bubble_cnt_o), 0);
        chk("rst stall_o", 32'(bus.stall_o), 0);
        chk("rst int_op1_o", 32'(bus.int_op1_o), 0);
        rst_i = 1;

        for (int i = 0; i < vq.size(); i++) begin
            t = vq[i];
            drive(t);
            #1;
            chk($sformatf("v%0d stall_o", i), 32'(bus.stall_o), 32'(t.e_stall));
            @(posedge clk_i);
            #1;
            check_outs($sformatf("v%0d", i), t);
        end

        // reset from HALT
        rst_i = 0;
        @(posedge clk_i);
        #1;
        chk("halt-rst halted_o", 32'(bus.halted_o), 0);
        chk("halt-rst valid_o", 32'(bus.valid_o), 0);
        chk("halt-rst bubble_cnt_o", 32'(bus.bubble_cnt_o), 0);
        chk("halt-rst ctrl_o", 32'(bus.ctrl_o), 32'(C_NOP));
        chk("halt-rst stall_o", 32'(bus.stall_o), 0);
        rst_i = 1;

        // reset while a load-use stall is active
        bus.valid_i = 1; bus.flush_i = 0; bus.hold_i = 0; bus.ctrl_i = C_LD;
        bus.int_dest_i = 4'd6; bus.int_src_use_i = 2'b00; bus.int_op1_i = 16'h4444;
        bus.v_src_use_i = 2'b00;
        @(posedge clk_i);
        #1;
        chk("mid load ctrl_o", 32'(bus.ctrl_o), 32'(C_LD));
        bus.ctrl_i = C_ALU; bus.int_src1_i = 4'd6; bus.int_src_use_i = 2'b01;
        bus.int_op1_i = 16'h5555;
        #1;
        chk("mid stall_o", 32'(bus.stall_o), 1);
        rst_i = 0;
        @(posedge clk_i);
        #1;
        chk("mid-rst valid_o", 32'(bus.valid_o), 0);
        chk("mid-rst bubble_cnt_o", 32'(bus.bubble_cnt_o), 0);
        chk("mid-rst stall_o", 32'(bus.stall_o), 0);
        rst_i = 1;
        @(posedge clk_i);
        #1;
        chk("post-rst int_op1_o", 32'(bus.int_op1_o), 32'h5555);
        chk("post-rst valid_o", 32'(bus.valid_o), 1);
        chk("post-rst bubble_cnt_o", 32'(bus.bubble_cnt_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
